m_dm: RTL and testbench

M_DM -- requirements
Module: M_DM

---
 rtl/m_dm.sv | 107 ++++++++++
 tb/tb_m_dm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_dm.sv
// M-stage data memory: byte-lane writable word array with combinational loads,
// sub-word sign/zero extension and address-error flags.
module m_dm #(
    parameter int          DEPTH      = 3072,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_WE,
    input  logic        M_RE,
    input  logic [2:0]  M_DMOp,
    input  logic [31:0] M_AO,
    input  logic [31:0] M_WD,
    output logic [31:0] M_DR,
    output logic [3:0]  M_BE,
    output logic        M_AdEL,
    output logic        M_AdES
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_W   = 3'b000,
        OP_H   = 3'b001,
        OP_HU  = 3'b010,
        OP_B   = 3'b011,
        OP_BU  = 3'b100
    } dm_op_e;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic          aligned;
    logic          acc_legal;
    logic          store_en;
    logic [31:0]   wd_rep;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;

    assign idx = M_AO[AW+1:2];

    // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        M_BE    = 4'b0000;
        aligned = 1'b0;
        wd_rep  = M_WD;
        case (M_DMOp)
            OP_W: begin
                M_BE    = 4'b1111;
                aligned = (M_AO[1:0] == 2'b00);
            end
            OP_H, OP_HU: begin
                M_BE    = M_AO[1] ? 4'b1100 : 4'b0011;
                aligned = ~M_AO[0];
                wd_rep  = {2{M_WD[15:0]}};
            end
            OP_B, OP_BU: begin
                M_BE    = 4'b0001 << M_AO[1:0];
                aligned = 1'b1;
                wd_rep  = {4{M_WD[7:0]}};
            end
            default: ;
        endcase
    end

    // Unsigned compare also rejects the upper half of the address space, so the index never wraps.
    assign acc_legal = aligned && (M_AO < ADDR_LIMIT);

    // A store colliding with a load in the same instruction slot is refused outright.
    assign store_en = M_WE && !M_RE && acc_legal;
    assign M_AdES   = M_WE && (M_RE || !acc_legal);
    assign M_AdEL   = M_RE && !acc_legal;

    // NOTE: the whole array is cleared by the async reset, and state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (M_BE[l]) begin
                    mem_q[idx][8*l +: 8] <= wd_rep[8*l +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word  = '0;
        rd_shift = '0;
        M_DR     = '0;
        if (M_RE && acc_legal) begin
            rd_word  = mem_q[idx];
            rd_shift = rd_word >> {M_AO[1:0], 3'b000};
            case (M_DMOp)
                OP_W:    M_DR = rd_word;
                OP_H:    M_DR = {{16{rd_shift[15]}}, rd_shift[15:0]};
                OP_HU:   M_DR = {16'h0000, rd_shift[15:0]};
                OP_B:    M_DR = {{24{rd_shift[7]}}, rd_shift[7:0]};
                OP_BU:   M_DR = {24'h000000, rd_shift[7:0]};
                default: M_DR = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_m_dm.sv
// Self-checking bench for m_dm: directed scenarios plus randomized accesses
// compared against a byte-addressed reference memory.
module tb_m_dm;

    logic        clk;
    logic        reset;
    logic        M_WE;
    logic        M_RE;
    logic [2:0]  M_DMOp;
    logic [31:0] M_AO;
    logic [31:0] M_WD;
    logic [31:0] M_DR;
    logic [3:0]  M_BE;
    logic        M_AdEL;
    logic        M_AdES;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] LIMIT = 32'h0000_3000;

    logic [7:0] ref_mem [0:12287];

    m_dm dut (
        .clk    (clk),
        .reset  (reset),
        .M_WE   (M_WE),
        .M_RE   (M_RE),
        .M_DMOp (M_DMOp),
        .M_AO   (M_AO),
        .M_WD   (M_WD),
        .M_DR   (M_DR),
        .M_BE   (M_BE),
        .M_AdEL (M_AdEL),
        .M_AdES (M_AdES)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int access_bytes(input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] op, input logic [31:0] ao);
        int n = access_bytes(op);
        if (n == 0) return 1'b0;
        if (ao >= LIMIT) return 1'b0;
        return (ao % n) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] ao);
        int n = access_bytes(op);
        int first = (n == 0) ? 0 : (ao[1:0] / n) * n;
        logic [3:0] be = 4'b0000;
        for (int b = 0; b < n; b++) be[first + b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_dr(input logic re, input logic [2:0] op, input logic [31:0] ao);
        longint v = 0;
        int n = access_bytes(op);
        if (!re || !is_legal(op, ao)) return 32'h0;
        for (int b = n - 1; b >= 0; b--) v = v * 256 + ref_mem[ao + b];
        if ((op == 3'd1 || op == 3'd3) && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] ao, input logic [31:0] wd);
        int n = access_bytes(op);
        for (int b = 0; b < n; b++) ref_mem[ao + b] = wd[8*b +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 12288; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] ao, input logic [31:0] wd);
        M_WE = we; M_RE = re; M_DMOp = op; M_AO = ao; M_WD = wd;
    endtask

    task automatic check_outputs(input string tag);
        logic lg;
        lg = is_legal(M_DMOp, M_AO);
        check({tag, "_be"},   {28'h0, M_BE},   {28'h0, exp_be(M_DMOp, M_AO)});
        check({tag, "_adel"}, {31'h0, M_AdEL}, {31'h0, M_RE && !lg});
        check({tag, "_ades"}, {31'h0, M_AdES}, {31'h0, M_WE && (M_RE || !lg)});
        check({tag, "_dr"},   M_DR,            exp_dr(M_RE, M_DMOp, M_AO));
    endtask

    // Apply one access, check the combinational outputs, then clock it in.
    task automatic step(input string tag, input logic we, input logic re, input logic [2:0] op,
                        input logic [31:0] ao, input logic [31:0] wd);
        drive(we, re, op, ao, wd);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (reset && we && !re && is_legal(op, ao)) model_store(op, ao, wd);
        #1;
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 32'h0000_0010, 32'h0);
        #3;
        check_outputs("rst_lw");
        check("rst_dr0", M_DR, 32'h0);
        check("rst_be", {28'h0, M_BE}, 32'hF);
        #19 reset = 1'b1;
        @(posedge clk); #1;

        // Word store and load
        step("sw10", 1, 0, 3'd0, 32'h10, 32'h1234_5678);
        step("lw10", 0, 1, 3'd0, 32'h10, 32'h0);
        check("lw10_val", M_DR, 32'h1234_5678);
        check("lw10_be", {28'h0, M_BE}, 32'hF);

        // Sub-word stores and extended loads
        step("sb21", 1, 0, 3'd3, 32'h21, 32'h0000_008A);
        step("sh22", 1, 0, 3'd1, 32'h22, 32'h0000_BEEF);
        step("lw20", 0, 1, 3'd0, 32'h20, 32'h0);
        check("lw20_val", M_DR, 32'hBEEF_8A00);
        step("lb21", 0, 1, 3'd3, 32'h21, 32'h0);
        check("lb21_val", M_DR, 32'hFFFF_FF8A);
        step("lbu21", 0, 1, 3'd4, 32'h21, 32'h0);
        check("lbu21_val", M_DR, 32'h0000_008A);
        step("lh22", 0, 1, 3'd1, 32'h22, 32'h0);
        check("lh22_val", M_DR, 32'hFFFF_BEEF);
        step("lhu22", 0, 1, 3'd2, 32'h22, 32'h0);
        check("lhu22_val", M_DR, 32'h0000_BEEF);

        // Misalignment
        step("sw04", 1, 0, 3'd0, 32'h04, 32'h1122_3344);
        step("sw06", 1, 0, 3'd0, 32'h06, 32'hDEAD_BEEF);
        step("lw04", 0, 1, 3'd0, 32'h04, 32'h0);
        check("lw04_val", M_DR, 32'h1122_3344);
        step("lh03", 0, 1, 3'd1, 32'h03, 32'h0);
        check("lh03_adel", {31'h0, M_AdEL}, 32'h1);

        // Address limits
        step("sw2ffc", 1, 0, 3'd0, 32'h2FFC, 32'hCAFE_F00D);
        step("lw2ffc", 0, 1, 3'd0, 32'h2FFC, 32'h0);
        check("lw2ffc_val", M_DR, 32'hCAFE_F00D);
        step("lw3000", 0, 1, 3'd0, 32'h3000, 32'h0);
        check("lw3000_adel", {31'h0, M_AdEL}, 32'h1);
        step("sw3000", 1, 0, 3'd0, 32'h3000, 32'h7777_7777);
        step("sw8000", 1, 0, 3'd0, 32'h8000_0000, 32'h6666_6666);
        step("lw00", 0, 1, 3'd0, 32'h0, 32'h0);
        check("lw00_val", M_DR, 32'h0);
        step("lb_illop", 0, 1, 3'd5, 32'h10, 32'h0);

        // Store and load in one slot: pre-edge data is read and the store is refused
        step("swlw40", 1, 1, 3'd0, 32'h40, 32'hA5A5_A5A5);
        check("swlw40_post", M_DR, 32'h0);
        step("sw40", 1, 0, 3'd0, 32'h40, 32'hA5A5_A5A5);
        step("lw40", 0, 1, 3'd0, 32'h40, 32'h0);
        check("lw40_val", M_DR, 32'hA5A5_A5A5);

        // Asynchronous reset between edges
        step("sw0ff", 1, 0, 3'd0, 32'h0, 32'hFFFF_FFFF);
        drive(0, 1, 3'd0, 32'h0, 32'h0);
        #1;
        check("lw0_pre", M_DR, 32'hFFFF_FFFF);
        #1 reset = 1'b0;
        model_clear();
        #1;
        check("arst_dr", M_DR, 32'h0);
        check_outputs("arst");
        drive(1, 0, 3'd0, 32'h0, 32'hFFFF_FFFF);
        #1;
        check_outputs("arst_sw");
        @(posedge clk); #1;
        drive(0, 1, 3'd0, 32'h0, 32'h0);
        #1;
        check("arst_after_edge", M_DR, 32'h0);
        reset = 1'b1;
        step("rel_sw", 1, 0, 3'd0, 32'h0, 32'h0000_005A);
        step("rel_lw", 0, 1, 3'd0, 32'h0, 32'h0);
        check("rel_lw_val", M_DR, 32'h0000_005A);

        // Randomized accesses against the byte-level model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  op;
            logic [31:0] ao;
            logic        we, re;
            op = ($urandom % 10 < 9) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
            case ($urandom % 8)
                0, 1, 2, 3, 4: ao = $urandom_range(0, 255);
                5:             ao = $urandom_range(32'h2F00, 32'h30FF);
                6:             ao = $urandom;
                default:       ao = $urandom | 32'h8000_0000;
            endcase
            we = 1'($urandom % 2);
            re = 1'($urandom % 2);
            step("rnd", we, re, op, ao, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
